// File: rtl/map_ss_seq.sv
// map_ss_seq: walks every mapper register slot over the save-state bus and
//   copies it to (save) or from (restore) a byte-wide buffer RAM.
// Latency: save (SETUP_CYC+1)/word; restore SETUP_CYC+1 id check, then 7
//   cycles/word, +1 FIN (checksum adds 1 save / 2 restore cycles).
// Backpressure: none; cmd_go while busy is ignored, abort cancels at once.
//
// Ports:
//   clk, map_rst          clock, synchronous active-high reset
//   cmd_go/cmd_dir/abort  start pulse, direction (0 save, 1 restore), cancel
//   busy/done/err         in progress, completion pulse, sticky error
//   ss_act/ss_we/ss_addr/ss_wdat/ss_rdat   save-state register bus
//   buf_addr/buf_re/buf_we/buf_wdat/buf_rdat  buffer RAM (1-cycle read)
//
// Optional build macro SS_SEQ_CHECKSUM_EN: adds a mod-256 checksum word at
// buffer address SS_WORDS, written on save and verified on restore.
module map_ss_seq #(
  parameter int SS_WORDS  = 128,
  parameter int SETUP_CYC = 2,
  parameter int WE_CYC    = 4
) (
  input  logic       clk,
  input  logic       map_rst,
  input  logic       cmd_go,
  input  logic       cmd_dir,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic [7:0] buf_addr,
  output logic       buf_re,
  output logic       buf_we,
  output logic [7:0] buf_wdat,
  input  logic [7:0] buf_rdat
);

  localparam logic [7:0] LAST    = 8'(SS_WORDS - 1);  // map_idx slot
  localparam logic [7:0] LAST_WR = 8'(SS_WORDS - 2);  // last writable slot

  typedef enum logic [3:0] {
    IDLE, ID_RD, ID_CMP, S_SET, S_CAP, R_RD, R_WAIT, R_WR, R_GAP,
`ifdef SS_SEQ_CHECKSUM_EN
    CK,
`endif
    FIN
  } state_t;

  state_t     state, state_n;
  logic [7:0] i;        // register slot index
  logic [7:0] cyc;      // cycles spent in the current state
  logic       err_q;
  logic [7:0] wdat_q;   // restore byte, held stable for the whole write
  logic       start, i_inc, err_set;
`ifdef SS_SEQ_CHECKSUM_EN
  logic       dir_q;    // only CK needs the direction; other states imply it
  logic [7:0] sum;
`endif

  assign err = err_q;

  always_comb begin
    state_n  = state;
    busy     = (state != IDLE) && (state != FIN);
    ss_act   = (state != IDLE) && (state != FIN);
    done     = 1'b0;
    ss_we    = 1'b0;
    ss_addr  = 8'h00;
    ss_wdat  = 8'h00;
    buf_addr = 8'h00;
    buf_re   = 1'b0;
    buf_we   = 1'b0;
    buf_wdat = 8'h00;
    start    = 1'b0;
    i_inc    = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_go && !abort) begin
          start   = 1'b1;
          state_n = cmd_dir ? ID_RD : S_SET;
        end
      end
      ID_RD: begin
        // Read the saved id while the mapper read-mux settles on its own id.
        ss_addr  = LAST;
        buf_addr = LAST;
        buf_re   = 1'b1;
        if (cyc == 8'(SETUP_CYC - 1)) state_n = ID_CMP;
      end
      ID_CMP: begin
        ss_addr = LAST;
        if (buf_rdat != ss_rdat) begin
          err_set = 1'b1;
          state_n = FIN;
        end else begin
          state_n = R_RD;
        end
      end
      S_SET: begin
        ss_addr = i;
        if (cyc == 8'(SETUP_CYC - 1)) state_n = S_CAP;
      end
      S_CAP: begin
        ss_addr  = i;
        buf_we   = 1'b1;
        buf_addr = i;
        buf_wdat = ss_rdat;
        if (i == LAST) begin
`ifdef SS_SEQ_CHECKSUM_EN
          state_n = CK;
`else
          state_n = FIN;
`endif
        end else begin
          i_inc   = 1'b1;
          state_n = S_SET;
        end
      end
      R_RD: begin
        ss_addr  = i;
        buf_addr = i;
        buf_re   = 1'b1;
        state_n  = R_WAIT;
      end
      R_WAIT: begin
        ss_addr = i;
        state_n = R_WR;
      end
      R_WR: begin
        ss_addr = i;
        ss_wdat = wdat_q;
        ss_we   = 1'b1;
        if (cyc == 8'(WE_CYC - 1)) state_n = R_GAP;
      end
      R_GAP: begin
        // Strobe low with address/data unchanged so the write closes cleanly.
        ss_addr = i;
        ss_wdat = wdat_q;
        if (i == LAST_WR) begin
`ifdef SS_SEQ_CHECKSUM_EN
          state_n = CK;
`else
          state_n = FIN;
`endif
        end else begin
          i_inc   = 1'b1;
          state_n = R_RD;
        end
      end
`ifdef SS_SEQ_CHECKSUM_EN
      CK: begin
        buf_addr = 8'(SS_WORDS);
        if (!dir_q) begin
          buf_we   = 1'b1;
          buf_wdat = sum;
          state_n  = FIN;
        end else if (cyc == 8'h00) begin
          buf_re = 1'b1;
        end else begin
          if (buf_rdat != sum) err_set = 1'b1;
          state_n = FIN;
        end
      end
`endif
      FIN: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Abort wins over whatever the walk wanted to do this cycle.
    if (abort && (state != IDLE) && (state != FIN)) begin
      state_n = IDLE;
      err_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (map_rst) begin
      state  <= IDLE;
      i      <= 8'h00;
      cyc    <= 8'h00;
      err_q  <= 1'b0;
      wdat_q <= 8'h00;
`ifdef SS_SEQ_CHECKSUM_EN
      dir_q  <= 1'b0;
      sum    <= 8'h00;
`endif
    end else begin
      state <= state_n;
      if (state_n != state) cyc <= 8'h00;
      else if (state != IDLE) cyc <= cyc + 8'h01;
      if (start) begin
        i     <= 8'h00;
        err_q <= 1'b0;
      end else if (i_inc) begin
        i <= i + 8'h01;
      end
      if (err_set) err_q <= 1'b1;
      if (state == R_WAIT) wdat_q <= buf_rdat;
`ifdef SS_SEQ_CHECKSUM_EN
      if (start) begin
        dir_q <= cmd_dir;
        sum   <= 8'h00;
      end else begin
        case (state)
          S_CAP:   sum <= sum + ss_rdat;
          ID_CMP:  sum <= buf_rdat;          // restore sum starts from the id
          R_WAIT:  sum <= sum + buf_rdat;
          default: sum <= sum;
        endcase
      end
`endif
    end
  end

endmodule

// File: tb/tb_map_ss_seq.sv
module tb_map_ss_seq;

  logic       clk = 1'b0;
  logic       map_rst, cmd_go, cmd_dir, abort;
  logic       busy, done, err, ss_act, ss_we, buf_re, buf_we;
  logic [7:0] ss_addr, ss_wdat, ss_rdat, buf_addr, buf_wdat, buf_rdat;

  logic [7:0]  mapper [0:255];
  logic [7:0]  bufm   [0:255];
  logic [7:0]  rd_q;
  logic [15:0] exp_buf[$], obs_buf[$], exp_ss[$], obs_ss[$];

  int n_checks = 0, n_fail = 0;
  int done_cnt = 0, pulses = 0, w127 = 0, bad_len = 0, unstable = 0, gap_bad = 0;
  int run_len = 0;
  logic       we_d = 1'b0;
  logic [7:0] addr_d = 8'h00, wdat_d = 8'h00;

  map_ss_seq dut (
    .clk(clk), .map_rst(map_rst), .cmd_go(cmd_go), .cmd_dir(cmd_dir), .abort(abort),
    .busy(busy), .done(done), .err(err), .ss_act(ss_act), .ss_we(ss_we),
    .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
    .buf_addr(buf_addr), .buf_re(buf_re), .buf_we(buf_we), .buf_wdat(buf_wdat),
    .buf_rdat(buf_rdat)
  );

  always #5 clk = ~clk;

  // Mapper read-back is combinational on the address.
  assign ss_rdat  = mapper[ss_addr];
  assign buf_rdat = rd_q;

  // Buffer RAM: synchronous write, registered read.
  always @(posedge clk) begin
    if (buf_we) bufm[buf_addr] = buf_wdat;
    if (buf_re) rd_q <= bufm[buf_addr];
  end

  // Bus monitor: mapper latches on each ss_we rising edge; record strobe shape.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (buf_we) obs_buf.push_back({buf_addr, buf_wdat});
    if (ss_we) begin
      if (!we_d) begin
        pulses++;
        obs_ss.push_back({ss_addr, ss_wdat});
        if (ss_addr == 8'd127) w127++;
        mapper[ss_addr] = ss_wdat;
        run_len = 1;
      end else begin
        run_len++;
        if (ss_addr != addr_d || ss_wdat != wdat_d) unstable++;
      end
    end else if (we_d) begin
      if (run_len != 4) bad_len++;
      if (ss_addr != addr_d) gap_bad++;
    end
    we_d = ss_we; addr_d = ss_addr; wdat_d = ss_wdat;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [7:0] ref_reg(input int k);
    case (k)
      0:       return 8'h1F;
      1:       return 8'h0A;
      2:       return 8'h03;
      3:       return 8'h01;
      127:     return 8'hAB;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clear_mon;
    pulses = 0; w127 = 0; bad_len = 0; unstable = 0; gap_bad = 0;
    exp_buf.delete(); obs_buf.delete(); exp_ss.delete(); obs_ss.delete();
  endtask

  // Issue a command and wait (bounded) for done; cycles counts the cmd_go
  // cycle through the done cycle inclusive.
  task automatic run_cmd(input logic dir, output int cycles, output logic got);
    cmd_go = 1'b1; cmd_dir = dir; cycles = 1;
    tick; cmd_go = 1'b0; cycles++;
    while (!done && cycles < 3000) begin tick; cycles++; end
    got = done;
  endtask

  task automatic test_reset;
    map_rst = 1'b1; cmd_go = 1'b0; cmd_dir = 1'b0; abort = 1'b0;
    tick; tick;
    map_rst = 1'b0;
    n_checks++; if ({busy, done, err, ss_act, ss_we} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, err, ss_act, ss_we}); end
    n_checks++; if ({ss_addr, ss_wdat} !== 16'h0) begin
      n_fail++; $display("FAIL reset_ss_bus: got %h expected 0000", {ss_addr, ss_wdat}); end
    n_checks++; if ({buf_re, buf_we, buf_addr, buf_wdat} !== 18'h0) begin
      n_fail++; $display("FAIL reset_buf_bus: got %h expected 0", {buf_re, buf_we, buf_addr, buf_wdat}); end
  endtask

  task automatic test_save;
    int cyc; logic got; logic [15:0] o, e; logic [7:0] s; int expc;
    clear_mon();
    s = 8'h00;
    for (int k = 0; k < 128; k++) begin
      mapper[k] = ref_reg(k);
      bufm[k] = 8'h00;
      exp_buf.push_back({8'(k), ref_reg(k)});
      s = s + ref_reg(k);
    end
    expc = 128 * 3 + 2;
`ifdef SS_SEQ_CHECKSUM_EN
    exp_buf.push_back({8'd128, s});
    expc = expc + 1;
`endif
    run_cmd(1'b0, cyc, got);
    n_checks++; if (got !== 1'b1) begin
      n_fail++; $display("FAIL save_done: got %b expected 1", got); end
    n_checks++; if (cyc != expc) begin
      n_fail++; $display("FAIL save_latency: got %0d expected %0d", cyc, expc); end
    n_checks++; if ({busy, ss_act, err} !== 3'b000) begin
      n_fail++; $display("FAIL save_fin_flags: got %b expected 000", {busy, ss_act, err}); end
    n_checks++; if (obs_buf.size() != exp_buf.size()) begin
      n_fail++; $display("FAIL save_write_count: got %0d expected %0d", obs_buf.size(), exp_buf.size()); end
    while (exp_buf.size() > 0 && obs_buf.size() > 0) begin
      e = exp_buf.pop_front(); o = obs_buf.pop_front();
      n_checks++; if (o !== e) begin
        n_fail++; $display("FAIL save_write: got %h expected %h", o, e); end
    end
    for (int k = 0; k < 128; k++) begin
      n_checks++; if (bufm[k] !== ref_reg(k)) begin
        n_fail++; $display("FAIL save_buffer[%0d]: got %h expected %h", k, bufm[k], ref_reg(k)); end
    end
`ifdef SS_SEQ_CHECKSUM_EN
    n_checks++; if (bufm[128] !== s) begin
      n_fail++; $display("FAIL save_checksum: got %h expected %h", bufm[128], s); end
`endif
    tick;
  endtask

  task automatic test_restore;
    int cyc; logic got; logic [15:0] o, e; int expc;
    clear_mon();
    for (int k = 0; k < 127; k++) begin
      mapper[k] = 8'h00;
      exp_ss.push_back({8'(k), bufm[k]});
    end
    mapper[127] = 8'hAB;
    expc = 1 + 2 + 1 + 127 * 7 + 1;
`ifdef SS_SEQ_CHECKSUM_EN
    expc = expc + 2;
`endif
    run_cmd(1'b1, cyc, got);
    n_checks++; if (got !== 1'b1) begin
      n_fail++; $display("FAIL restore_done: got %b expected 1", got); end
    n_checks++; if (cyc != expc) begin
      n_fail++; $display("FAIL restore_latency: got %0d expected %0d", cyc, expc); end
    n_checks++; if (err !== 1'b0) begin
      n_fail++; $display("FAIL restore_err: got %b expected 0", err); end
    n_checks++; if (pulses != 127) begin
      n_fail++; $display("FAIL restore_pulses: got %0d expected 127", pulses); end
    n_checks++; if ({bad_len, unstable, gap_bad, w127} != 0) begin
      n_fail++; $display("FAIL restore_strobe_shape: got len=%0d unstable=%0d gap=%0d w127=%0d expected all 0",
                         bad_len, unstable, gap_bad, w127); end
    while (exp_ss.size() > 0 && obs_ss.size() > 0) begin
      e = exp_ss.pop_front(); o = obs_ss.pop_front();
      n_checks++; if (o !== e) begin
        n_fail++; $display("FAIL restore_write: got %h expected %h", o, e); end
    end
    for (int k = 0; k < 127; k++) begin
      n_checks++; if (mapper[k] !== ref_reg(k)) begin
        n_fail++; $display("FAIL restore_reg[%0d]: got %h expected %h", k, mapper[k], ref_reg(k)); end
    end
    n_checks++; if (mapper[127] !== 8'hAB) begin
      n_fail++; $display("FAIL restore_id_kept: got %h expected ab", mapper[127]); end
    tick;
  endtask

  task automatic test_id_mismatch;
    int cyc; logic got;
    clear_mon();
    bufm[127] = 8'hAC;
    run_cmd(1'b1, cyc, got);
    n_checks++; if (got !== 1'b1) begin
      n_fail++; $display("FAIL idmm_done: got %b expected 1", got); end
    n_checks++; if (cyc != 5) begin
      n_fail++; $display("FAIL idmm_latency: got %0d expected 5", cyc); end
    n_checks++; if (err !== 1'b1) begin
      n_fail++; $display("FAIL idmm_err: got %b expected 1", err); end
    n_checks++; if (pulses != 0) begin
      n_fail++; $display("FAIL idmm_pulses: got %0d expected 0", pulses); end
    bufm[127] = 8'hAB;
    tick;
  endtask

`ifdef SS_SEQ_CHECKSUM_EN
  task automatic test_checksum;
    int cyc; logic got;
    clear_mon();
    bufm[5] = bufm[5] ^ 8'h5A;
    run_cmd(1'b1, cyc, got);
    n_checks++; if (got !== 1'b1) begin
      n_fail++; $display("FAIL cks_done: got %b expected 1", got); end
    n_checks++; if (err !== 1'b1) begin
      n_fail++; $display("FAIL cks_err: got %b expected 1", err); end
    n_checks++; if (pulses != 127) begin
      n_fail++; $display("FAIL cks_pulses: got %0d expected 127", pulses); end
    tick;
  endtask
`endif

  task automatic test_abort;
    int n; int base;
    clear_mon();
    cmd_go = 1'b1; cmd_dir = 1'b1;
    tick; cmd_go = 1'b0;
    n = 0;
    while (pulses < 10 && n < 2000) begin tick; n++; end
    n_checks++; if (pulses != 10 || ss_we !== 1'b1) begin
      n_fail++; $display("FAIL abort_reach_10th: got pulses=%0d we=%b expected 10/1", pulses, ss_we); end
    abort = 1'b1;
    tick; abort = 1'b0;
    base = done_cnt;
    n_checks++; if ({ss_we, ss_act, busy, err} !== 4'b0001) begin
      n_fail++; $display("FAIL abort_state: got %b expected 0001", {ss_we, ss_act, busy, err}); end
    repeat (5) tick;
    n_checks++; if (done_cnt != base) begin
      n_fail++; $display("FAIL abort_no_done: got %0d expected %0d", done_cnt, base); end
    cmd_go = 1'b1; cmd_dir = 1'b0;
    tick; cmd_go = 1'b0;
    n_checks++; if ({err, busy} !== 2'b01) begin
      n_fail++; $display("FAIL abort_err_clear: got %b expected 01", {err, busy}); end
    map_rst = 1'b1; tick; map_rst = 1'b0;
  endtask

  task automatic test_busy_and_reset;
    int bad; int base;
    clear_mon();
    base = done_cnt;
    cmd_go = 1'b1; cmd_dir = 1'b0;
    tick; cmd_go = 1'b0;
    repeat (20) tick;
    cmd_go = 1'b1; cmd_dir = 1'b1;
    tick; cmd_go = 1'b0;
    n_checks++; if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_go_busy: got %b expected 1", busy); end
    bad = 0;
    repeat (50) begin tick; if (ss_we || buf_re) bad++; end
    n_checks++; if (bad != 0) begin
      n_fail++; $display("FAIL busy_go_ignored: got %0d restore cycles expected 0", bad); end
    n_checks++; if (obs_buf.size() != 23) begin
      n_fail++; $display("FAIL busy_save_progress: got %0d writes expected 23", obs_buf.size()); end
    map_rst = 1'b1;
    tick; map_rst = 1'b0;
    n_checks++; if ({busy, done, err, ss_act, ss_we, buf_re, buf_we} !== 7'b0) begin
      n_fail++; $display("FAIL midrst_flags: got %b expected 0000000",
                         {busy, done, err, ss_act, ss_we, buf_re, buf_we}); end
    n_checks++; if ({ss_addr, ss_wdat, buf_addr, buf_wdat} !== 32'h0) begin
      n_fail++; $display("FAIL midrst_buses: got %h expected 0", {ss_addr, ss_wdat, buf_addr, buf_wdat}); end
    repeat (400) tick;
    n_checks++; if (done_cnt != base || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_no_done: got done=%0d busy=%b expected %0d/0", done_cnt, busy, base); end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin mapper[k] = 8'h00; bufm[k] = 8'h00; end
    rd_q = 8'h00;
    map_rst = 1'b1; cmd_go = 1'b0; cmd_dir = 1'b0; abort = 1'b0;
    test_reset();
    test_save();
    test_restore();
    test_id_mismatch();
`ifdef SS_SEQ_CHECKSUM_EN
    test_checksum();
`endif
    test_abort();
    test_busy_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
